// File: rtl/can_destuff_ctrl.sv
// CAN bit de-stuffing controller: tracks equal-bit runs, flags
// stuff bits for removal, and latches stuff-rule violations.
//
// Ports:
//   Clock_SP        in   rising-edge clock
//   Reset           in   synchronous active-high reset
//   Sample_Valid    in   qualifies Bit_Input/Frame_Start/Destuff_Enable
//   Bit_Input       in   sampled bus bit (0 dominant)
//   Frame_Start     in   sampled bit is SOF
//   Destuff_Enable  in   1 inside the stuffed region
//   Bit_Output      out  last qualified bit
//   Bit_Valid       out  pulse: Bit_Output is data
//   Ignora_Bit      out  pulse: Bit_Output is a stuff bit
//   Error_Stuffing  out  sticky stuff violation
//   Stuff_Count     out  stuff bits removed this frame (mod 8)
//   Run_Length      out  current equal-bit run length
module can_destuff_ctrl #(
    parameter int STUFF_LEN = 5,
    parameter int RUN_W     = 4
) (
    input  logic             Clock_SP,
    input  logic             Reset,
    input  logic             Sample_Valid,
    input  logic             Bit_Input,
    input  logic             Frame_Start,
    input  logic             Destuff_Enable,
    output logic             Bit_Output,
    output logic             Bit_Valid,
    output logic             Ignora_Bit,
    output logic             Error_Stuffing,
    output logic [2:0]       Stuff_Count,
    output logic [RUN_W-1:0] Run_Length
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [RUN_W-1:0] LIMIT = RUN_W'(STUFF_LEN);
    localparam logic [RUN_W-1:0] ONE   = RUN_W'(1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             bo_q, bo_d;
    logic             bv_q, bv_d;
    logic             ig_q, ig_d;

    logic at_limit;
    logic same_bit;

    assign at_limit = (run_q == LIMIT);
    assign same_bit = (Bit_Input == last_q);

    // State and output registers
    always_ff @(posedge Clock_SP) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            run_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bo_q    <= 1'b1;
            bv_q    <= 1'b0;
            ig_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bo_q    <= bo_d;
            bv_q    <= bv_d;
            ig_q    <= ig_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (Sample_Valid) begin
            if (Frame_Start) begin
                state_d = ST_RUN;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (Destuff_Enable && at_limit && same_bit)
                            state_d = ST_ERROR;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        last_d = last_q;
        run_d  = run_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        bo_d   = bo_q;
        bv_d   = 1'b0;
        ig_d   = 1'b0;
        if (Sample_Valid) begin
            bo_d = Bit_Input;
            if (Frame_Start) begin
                // SOF restarts the frame ahead of any stuff check
                bv_d   = 1'b1;
                run_d  = ONE;
                last_d = Bit_Input;
                cnt_d  = '0;
                err_d  = 1'b0;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (!Destuff_Enable) begin
                            // Run held at 0 so the first enabled
                            // bit can never be taken as stuff
                            bv_d   = 1'b1;
                            run_d  = '0;
                            last_d = Bit_Input;
                        end else if (at_limit) begin
                            if (!same_bit) begin
                                ig_d   = 1'b1;
                                cnt_d  = cnt_q + 3'd1;
                                run_d  = ONE;
                                last_d = Bit_Input;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            bv_d   = 1'b1;
                            last_d = Bit_Input;
                            run_d  = same_bit ? run_q + ONE : ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Bit_Output     = bo_q;
    assign Bit_Valid      = bv_q;
    assign Ignora_Bit     = ig_q;
    assign Error_Stuffing = err_q;
    assign Stuff_Count    = cnt_q;
    assign Run_Length     = run_q;

endmodule

// File: tb/tb_can_destuff_ctrl.sv
// Testbench for can_destuff_ctrl: vector table driven through a
// scoreboard queue, compared one cycle after each drive.
module tb_can_destuff_ctrl;

    logic       Clock_SP = 1'b0;
    logic       Reset = 1'b1;
    logic       Sample_Valid = 1'b0;
    logic       Bit_Input = 1'b1;
    logic       Frame_Start = 1'b0;
    logic       Destuff_Enable = 1'b0;
    logic       Bit_Output;
    logic       Bit_Valid;
    logic       Ignora_Bit;
    logic       Error_Stuffing;
    logic [2:0] Stuff_Count;
    logic [3:0] Run_Length;

    can_destuff_ctrl #(
        .STUFF_LEN(5),
        .RUN_W(4)
    ) dut (
        .Clock_SP(Clock_SP),
        .Reset(Reset),
        .Sample_Valid(Sample_Valid),
        .Bit_Input(Bit_Input),
        .Frame_Start(Frame_Start),
        .Destuff_Enable(Destuff_Enable),
        .Bit_Output(Bit_Output),
        .Bit_Valid(Bit_Valid),
        .Ignora_Bit(Ignora_Bit),
        .Error_Stuffing(Error_Stuffing),
        .Stuff_Count(Stuff_Count),
        .Run_Length(Run_Length)
    );

    always #5 Clock_SP = ~Clock_SP;

    typedef struct {
        logic       rst, sv, bi, fs, en;
        logic       bo, bv, ig, er;
        logic [2:0] sc;
        logic [3:0] rl;
    } vec_t;

    typedef struct {
        int         idx;
        logic       bo, bv, ig, er;
        logic [2:0] sc;
        logic [3:0] rl;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic rst, sv, b, fs, en,
                                input logic bo, bv, ig, er,
                                input int sc, rl);
        vec_t v;
        v.rst = rst; v.sv = sv; v.bi = b; v.fs = fs; v.en = en;
        v.bo = bo; v.bv = bv; v.ig = ig; v.er = er;
        v.sc = 3'(sc); v.rl = 4'(rl);
        return v;
    endfunction

    task automatic rs();
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic dv(input logic b, fs, en, bo, bv, ig, er,
                      input int sc, rl);
        tbl.push_back(mk(0, 1, b, fs, en, bo, bv, ig, er, sc, rl));
    endtask

    // Unqualified edge: junk inputs, pulses drop, everything else holds
    task automatic gap();
        vec_t v;
        v = tbl[tbl.size()-1];
        v.rst = 0; v.sv = 0; v.bi = ~v.bo; v.fs = 1; v.en = ~v.en;
        v.bv = 0; v.ig = 0;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, req);
        end
    endtask

    initial begin
        logic v;
        exp_t e;

        rs(); rs();
        // idle: bits without SOF give no pulses
        dv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        dv(1, 0, 1, 1, 0, 0, 0, 0, 0);
        // SOF 0, four 0s, stuff 1
        dv(0, 1, 1, 0, 1, 0, 0, 0, 1);
        for (int j = 2; j <= 5; j++) dv(0, 0, 1, 0, 1, 0, 0, 0, j);
        dv(1, 0, 1, 1, 0, 1, 0, 1, 1);
        gap();
        // stuff bit starts next run
        for (int j = 2; j <= 5; j++) dv(1, 0, 1, 1, 1, 0, 0, 1, j);
        dv(0, 0, 1, 0, 0, 1, 0, 2, 1);
        for (int j = 2; j <= 5; j++) dv(0, 0, 1, 0, 1, 0, 0, 2, j);
        dv(1, 0, 1, 1, 0, 1, 0, 3, 1);
        // stuff violation, sticky error, cleared by SOF
        dv(0, 1, 1, 0, 1, 0, 0, 0, 1);
        for (int j = 2; j <= 5; j++) dv(0, 0, 1, 0, 1, 0, 0, 0, j);
        dv(0, 0, 1, 0, 0, 0, 1, 0, 5);
        for (int k = 0; k < 10; k++) begin
            v = k[0];
            dv(v, 0, 1, v, 0, 0, 1, 0, 5);
        end
        gap();
        dv(1, 1, 1, 1, 1, 0, 0, 0, 1);
        // destuff disabled: eight 1s
        for (int k = 0; k < 8; k++) dv(1, 0, 0, 1, 1, 0, 0, 0, 0);
        dv(1, 0, 1, 1, 1, 0, 0, 0, 1);
        for (int j = 2; j <= 5; j++) dv(1, 0, 1, 1, 1, 0, 0, 0, j);
        dv(1, 0, 0, 1, 1, 0, 0, 0, 0);
        // SOF beats the stuff check at the limit
        dv(1, 0, 1, 1, 1, 0, 0, 0, 1);
        for (int j = 2; j <= 5; j++) dv(1, 0, 1, 1, 1, 0, 0, 0, j);
        dv(1, 1, 1, 1, 1, 0, 0, 0, 1);
        dv(0, 0, 1, 0, 1, 0, 0, 0, 1);
        dv(0, 0, 1, 0, 1, 0, 0, 0, 2);
        // reset mid-frame discards it
        dv(0, 1, 1, 0, 1, 0, 0, 0, 1);
        dv(1, 0, 1, 1, 1, 0, 0, 0, 1);
        dv(1, 0, 1, 1, 1, 0, 0, 0, 2);
        rs();
        dv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        dv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // nine stuff bits with gaps: counter wraps to 1
        dv(0, 1, 1, 0, 1, 0, 0, 0, 1);
        v = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            for (int j = 2; j <= 5; j++) begin
                dv(v, 0, 1, v, 1, 0, 0, (k - 1) % 8, j);
                gap();
            end
            dv(~v, 0, 1, ~v, 0, 1, 0, k % 8, 1);
            gap();
            v = ~v;
        end

        for (int i = 0; i < tbl.size(); i++) begin
            Reset          = tbl[i].rst;
            Sample_Valid   = tbl[i].sv;
            Bit_Input      = tbl[i].bi;
            Frame_Start    = tbl[i].fs;
            Destuff_Enable = tbl[i].en;
            e.idx = i;
            e.bo = tbl[i].bo; e.bv = tbl[i].bv;
            e.ig = tbl[i].ig; e.er = tbl[i].er;
            e.sc = tbl[i].sc; e.rl = tbl[i].rl;
            exp_q.push_back(e);
            @(posedge Clock_SP);
            #1;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty vec=%0d got=0 want=1", i);
            end else begin
                e = exp_q.pop_front();
                chk("bit_output", e.idx, 4'(Bit_Output), 4'(e.bo));
                chk("bit_valid", e.idx, 4'(Bit_Valid), 4'(e.bv));
                chk("ignora_bit", e.idx, 4'(Ignora_Bit), 4'(e.ig));
                chk("error_stuffing", e.idx, 4'(Error_Stuffing), 4'(e.er));
                chk("stuff_count", e.idx, 4'(Stuff_Count), 4'(e.sc));
                chk("run_length", e.idx, Run_Length, e.rl);
                chk("pulse_exclusive", e.idx,
                    4'(Bit_Valid & Ignora_Bit), 4'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
